seq_alu_exec: RTL



---
 rtl/seq_alu_exec.sv | 129 ++++++++++++
 1 files changed

// File: rtl/seq_alu_exec.sv
// EX-stage ALU: single-cycle ops plus iterative SLL/SRL under a start/busy/done handshake.
// Optional SEQ_ALU_SHIFT4_EN: shifts advance 4 bits per cycle while at least 4 remain.
module seq_alu_exec #(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned SHAMT_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start_i,
   input  logic [3:0]            ALU_Operation_i,
   input  logic [DATA_WIDTH-1:0] A_i,
   input  logic [DATA_WIDTH-1:0] B_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [DATA_WIDTH-1:0] ALU_Result_o,
   output logic                  Zero_o
);

   typedef enum logic [3:0] {
      OP_ADD = 4'b0000,
      OP_SUB = 4'b0001,
      OP_AND = 4'b0010,
      OP_XOR = 4'b0011,
      OP_LUI = 4'b1000,
      OP_OR  = 4'b1001,
      OP_SLL = 4'b1100,
      OP_SRL = 4'b1101
   } alu_op_t;

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t                  state_q, state_d;
   logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
   logic [SHAMT_WIDTH-1:0]  cnt_q, cnt_d;
   logic                    right_q, right_d;
   logic                    busy_d, done_d, zero_d;
   logic [DATA_WIDTH-1:0]   result_d;
   logic [DATA_WIDTH-1:0]   single_res;
   logic [SHAMT_WIDTH-1:0]  shamt;
   logic                    is_shift;

   assign shamt    = B_i[SHAMT_WIDTH-1:0];
   assign is_shift = (ALU_Operation_i == OP_SLL) || (ALU_Operation_i == OP_SRL);

   // Shifts with shamt 0 fall through here and return A unchanged.
   always_comb begin
      single_res = '0;
      case (ALU_Operation_i)
         OP_ADD:  single_res = A_i + B_i;
         OP_SUB:  single_res = A_i - B_i;
         OP_AND:  single_res = A_i & B_i;
         OP_XOR:  single_res = A_i ^ B_i;
         OP_LUI:  single_res = B_i;
         OP_OR:   single_res = A_i | B_i;
         OP_SLL:  single_res = A_i;
         OP_SRL:  single_res = A_i;
         default: single_res = '0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      shreg_d  = shreg_q;
      cnt_d    = cnt_q;
      right_d  = right_q;
      busy_d   = busy_o;
      done_d   = 1'b0;
      result_d = ALU_Result_o;
      zero_d   = Zero_o;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               if (is_shift && (shamt != '0)) begin
                  shreg_d = A_i;
                  cnt_d   = shamt;
                  right_d = (ALU_Operation_i == OP_SRL);
                  busy_d  = 1'b1;
                  state_d = SHIFT;
               end else begin
                  result_d = single_res;
                  zero_d   = (single_res == '0);
                  done_d   = 1'b1;
               end
            end
         end
         SHIFT: begin
            shreg_d = right_q ? (shreg_q >> 1) : (shreg_q << 1);
            cnt_d   = cnt_q - SHAMT_WIDTH'(1);
`ifdef SEQ_ALU_SHIFT4_EN
            if (cnt_q >= SHAMT_WIDTH'(4)) begin
               shreg_d = right_q ? (shreg_q >> 4) : (shreg_q << 4);
               cnt_d   = cnt_q - SHAMT_WIDTH'(4);
            end
`endif
            if (cnt_d == '0) begin
               result_d = shreg_d;
               zero_d   = (shreg_d == '0);
               done_d   = 1'b1;
               busy_d   = 1'b0;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         shreg_q      <= '0;
         cnt_q        <= '0;
         right_q      <= 1'b0;
         busy_o       <= 1'b0;
         done_o       <= 1'b0;
         ALU_Result_o <= '0;
         Zero_o       <= 1'b1;
      end else begin
         state_q      <= state_d;
         shreg_q      <= shreg_d;
         cnt_q        <= cnt_d;
         right_q      <= right_d;
         busy_o       <= busy_d;
         done_o       <= done_d;
         ALU_Result_o <= result_d;
         Zero_o       <= zero_d;
      end
   end

endmodule
